// File: rtl/pwm_key_ctrl.sv
// pwm_key_ctrl: turns up/down/mode key presses and holds into saturated PWM duty/period
// updates with auto-repeat, offered to the PWM generator over valid/ready.
module pwm_key_ctrl #(
  parameter int unsigned CLK_FREQ_Hz     = 27000000,
  parameter logic        KEY_IDLE        = 1'b1,
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DUTY_INIT       = 128,
  parameter int unsigned PERIOD_INIT     = 255,
  parameter int unsigned DUTY_STEP       = 8,
  parameter int unsigned PERIOD_STEP     = 16,
  parameter int unsigned PERIOD_MIN      = 16,
  parameter int unsigned REPEAT_DELAY_MS = 500,
  parameter int unsigned REPEAT_RATE_MS  = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_up_i,
  input  logic             key_down_i,
  input  logic             key_mode_i,
  input  logic             cfg_ready_i,
  output logic             cfg_valid_o,
  output logic [WIDTH-1:0] cfg_duty_o,
  output logic [WIDTH-1:0] cfg_period_o,
  output logic             mode_o
);
  localparam int unsigned DIV  = CLK_FREQ_Hz / 1000;
  localparam int unsigned PW   = $clog2(DIV + 1);
  localparam int unsigned MMAX = REPEAT_DELAY_MS > REPEAT_RATE_MS ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
  localparam int unsigned MW   = $clog2(MMAX + 1);
  localparam logic [WIDTH:0] SMAX = (WIDTH+1)'((1 << WIDTH) - 1);
  localparam logic [WIDTH:0] DS   = (WIDTH+1)'(DUTY_STEP);
  localparam logic [WIDTH:0] PS   = (WIDTH+1)'(PERIOD_STEP);
  localparam logic [WIDTH:0] PMIN = (WIDTH+1)'(PERIOD_MIN);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT, LOCK} state_e;

  state_e           state_q, state_d;
  logic [2:0]       smp_q, prv_q, prs, ev;
  logic             live_q, arm_q, tick;
  logic [PW-1:0]    pre_q;
  logic [MW-1:0]    ms_q, ms_d, lim;
  logic             dir_q, dir_d, step, act, oth;
  logic [WIDTH-1:0] duty_q, period_q, cduty_q, cper_q;
  logic [WIDTH:0]   d_w, p_w, d_up, d_dn, p_up, p_dn, d_nx, p_nx;
  logic             chg, load, dirty_q, dirty_d, valid_q, valid_d, mode_q;

  // key order {mode, down, up}; arm_q blocks presses until all keys are seen released after reset
  assign prs  = smp_q ^ {3{KEY_IDLE}};
  assign ev   = prs & ~(prv_q ^ {3{KEY_IDLE}}) & {3{arm_q}};
  assign tick = pre_q == PW'(DIV - 1);
  assign act  = dir_q ? prs[0] : prs[1];
  assign oth  = dir_q ? prs[1] : prs[0];
  assign lim  = state_q == HOLD ? MW'(REPEAT_DELAY_MS - 1) : MW'(REPEAT_RATE_MS - 1);

  always_comb begin
    state_d = state_q;
    ms_d    = ms_q;
    dir_d   = dir_q;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ev[0] && ev[1]) state_d = LOCK;
        else if (ev[0] || ev[1]) begin
          step    = 1'b1;
          dir_d   = ev[0];
          ms_d    = '0;
          state_d = HOLD;
        end
      end
      HOLD, REPEAT: begin
        if (!act) state_d = IDLE;
        else if (oth) state_d = LOCK;
        else if (tick) begin
          if (ms_q == lim) begin
            step    = 1'b1;
            ms_d    = '0;
            state_d = REPEAT;
          end else ms_d = ms_q + 1'b1;
        end
      end
      LOCK: state_d = (!prs[0] && !prs[1]) ? IDLE : LOCK;
      default: state_d = IDLE;
    endcase
  end

  // saturating step arithmetic one bit wider than the shadows
  assign d_w  = {1'b0, duty_q};
  assign p_w  = {1'b0, period_q};
  assign d_up = d_w + DS > p_w ? p_w : d_w + DS;
  assign d_dn = d_w > DS ? d_w - DS : '0;
  assign p_up = p_w + PS > SMAX ? SMAX : p_w + PS;
  assign p_dn = p_w > PMIN + PS ? p_w - PS : PMIN;
  assign p_nx = step && mode_q ? (dir_d ? p_up : p_dn) : p_w;
  assign d_nx = !step ? d_w : !mode_q ? (dir_d ? d_up : d_dn) : (d_w > p_nx ? p_nx : d_w);
  assign chg  = d_nx != d_w || p_nx != p_w;

  assign load    = !valid_q && dirty_q;
  assign valid_d = load || (valid_q && !cfg_ready_i);
  assign dirty_d = chg || (dirty_q && !load);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      smp_q    <= {3{KEY_IDLE}};
      prv_q    <= {3{KEY_IDLE}};
      live_q   <= 1'b0;
      arm_q    <= 1'b0;
      pre_q    <= '0;
      state_q  <= IDLE;
      ms_q     <= '0;
      dir_q    <= 1'b0;
      duty_q   <= WIDTH'(DUTY_INIT);
      period_q <= WIDTH'(PERIOD_INIT);
      cduty_q  <= WIDTH'(DUTY_INIT);
      cper_q   <= WIDTH'(PERIOD_INIT);
      dirty_q  <= 1'b1;
      valid_q  <= 1'b0;
      mode_q   <= 1'b0;
    end else begin
      smp_q    <= {key_mode_i, key_down_i, key_up_i};
      prv_q    <= smp_q;
      live_q   <= 1'b1;
      arm_q    <= arm_q || (live_q && prs == 3'b000);
      pre_q    <= tick ? '0 : pre_q + 1'b1;
      state_q  <= state_d;
      ms_q     <= ms_d;
      dir_q    <= dir_d;
      duty_q   <= d_nx[WIDTH-1:0];
      period_q <= p_nx[WIDTH-1:0];
      cduty_q  <= load ? duty_q : cduty_q;
      cper_q   <= load ? period_q : cper_q;
      dirty_q  <= dirty_d;
      valid_q  <= valid_d;
      mode_q   <= mode_q ^ ev[2];
    end
  end

  assign cfg_valid_o  = valid_q;
  assign cfg_duty_o   = cduty_q;
  assign cfg_period_o = cper_q;
  assign mode_o       = mode_q;
endmodule

// File: tb/tb_pwm_key_ctrl.sv
// tb_pwm_key_ctrl: directed scenarios plus random key presses against a step-level model.
module tb_pwm_key_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] key_n = 3'b111;
  logic       rdy = 1'b1;
  logic       cfg_valid_o, mode_o;
  logic [7:0] cfg_duty_o, cfg_period_o;

  int checks = 0;
  int errors = 0;
  int acc_n = 0;
  int acc_d = 0;
  int acc_p = 0;
  int cyc = 0;
  int rise_t[$];
  logic pv = 1'b0;
  logic pr = 1'b0;
  logic [7:0] pd, pp;

  pwm_key_ctrl #(.CLK_FREQ_Hz(10000), .REPEAT_DELAY_MS(5), .REPEAT_RATE_MS(2)) dut (
    .clk(clk), .rst(rst), .key_up_i(key_n[0]), .key_down_i(key_n[1]), .key_mode_i(key_n[2]),
    .cfg_ready_i(rdy), .cfg_valid_o(cfg_valid_o), .cfg_duty_o(cfg_duty_o),
    .cfg_period_o(cfg_period_o), .mode_o(mode_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic tk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int k, input int h);
    key_n[k] = 1'b0;
    tk(h);
    key_n[k] = 1'b1;
  endtask

  // handshake monitor: frozen outputs under backpressure, accepted configs, valid rise times
  always @(negedge clk) begin
    if (!rst) begin
      pv = 1'b0;
      pr = 1'b0;
    end else begin
      cyc++;
      if (pv && !pr) begin
        chk("frozen_valid", cfg_valid_o, 1);
        chk("frozen_duty", cfg_duty_o, pd);
        chk("frozen_period", cfg_period_o, pp);
      end
      if (cfg_valid_o && !pv) rise_t.push_back(cyc);
      if (cfg_valid_o && rdy) begin
        acc_n++;
        acc_d = cfg_duty_o;
        acc_p = cfg_period_o;
        chk("acc_duty_le_period", cfg_duty_o <= cfg_period_o, 1);
        chk("acc_period_ge_min", cfg_period_o >= 16, 1);
      end
      pv = cfg_valid_o;
      pr = rdy;
      pd = cfg_duty_o;
      pp = cfg_period_o;
    end
  end

  initial begin
    int n1, r0, m_d, m_p, m_m, k, h;
    tk(3);
    chk("rst_valid", cfg_valid_o, 0);
    chk("rst_duty", cfg_duty_o, 128);
    chk("rst_period", cfg_period_o, 255);
    chk("rst_mode", mode_o, 0);
    rst = 1'b1;
    tk(1);
    chk("por_valid", cfg_valid_o, 1);
    chk("por_duty", cfg_duty_o, 128);
    chk("por_period", cfg_period_o, 255);
    tk(1);
    chk("por_drop", cfg_valid_o, 0);
    tk(5);
    chk("por_quiet", cfg_valid_o, 0);
    chk("por_count", acc_n, 1);

    key_n[0] = 1'b0;
    tk(1);
    chk("up_e1", cfg_valid_o, 0);
    tk(1);
    chk("up_e2", cfg_valid_o, 0);
    tk(1);
    chk("up_e3", cfg_valid_o, 1);
    chk("up_duty", cfg_duty_o, 136);
    tk(17);
    key_n[0] = 1'b1;
    tk(5);
    chk("up_count", acc_n, 2);
    key_n[1] = 1'b0;
    tk(2);
    chk("dn_e2", cfg_valid_o, 0);
    tk(1);
    chk("dn_e3", cfg_valid_o, 1);
    chk("dn_duty", cfg_duty_o, 128);
    tk(10);
    key_n[1] = 1'b1;
    tk(5);
    chk("dn_count", acc_n, 3);

    rdy = 1'b0;
    repeat (3) begin
      press(0, 5);
      tk(5);
    end
    chk("bp_valid", cfg_valid_o, 1);
    chk("bp_frozen_duty", cfg_duty_o, 136);
    rdy = 1'b1;
    tk(1);
    rdy = 1'b0;
    chk("bp_gap", cfg_valid_o, 0);
    tk(1);
    chk("bp_revalid", cfg_valid_o, 1);
    chk("bp_duty", cfg_duty_o, 152);
    rdy = 1'b1;
    tk(3);
    chk("bp_drain", cfg_valid_o, 0);

    r0 = rise_t.size();
    key_n[0] = 1'b0;
    tk(100);
    key_n[0] = 1'b1;
    tk(5);
    chk("rep_rises", rise_t.size() - r0, 4);
    if (rise_t.size() - r0 >= 4) begin
      chk_rng("rep_first_gap", rise_t[r0+1] - rise_t[r0], 41, 50);
      chk("rep_gap2", rise_t[r0+2] - rise_t[r0+1], 20);
      chk("rep_gap3", rise_t[r0+3] - rise_t[r0+2], 20);
    end
    chk("rep_duty", acc_d, 184);
    key_n[0] = 1'b0;
    tk(300);
    n1 = acc_n;
    chk("sat_duty", acc_d, 255);
    tk(100);
    chk("sat_no_pulse", acc_n, n1);
    key_n[0] = 1'b1;
    tk(5);
    chk("sat_valid", cfg_valid_o, 0);

    key_n[2] = 1'b0;
    tk(1);
    chk("mode_e1", mode_o, 0);
    tk(1);
    chk("mode_e2", mode_o, 1);
    key_n[2] = 1'b1;
    tk(3);
    press(1, 5);
    tk(5);
    chk("pclamp_period", acc_p, 239);
    chk("pclamp_duty", acc_d, 239);
    key_n[1] = 1'b0;
    tk(400);
    key_n[1] = 1'b1;
    tk(5);
    chk("pmin_period", acc_p, 16);
    chk("pmin_duty", acc_d, 16);

    n1 = acc_n;
    key_n[1:0] = 2'b00;
    tk(30);
    chk("lock_both", acc_n, n1);
    key_n[0] = 1'b1;
    tk(5);
    key_n[0] = 1'b0;
    tk(10);
    chk("lock_repress", acc_n, n1);
    key_n[1:0] = 2'b11;
    tk(5);
    press(0, 5);
    tk(5);
    chk("unlock_step", acc_n, n1 + 1);
    chk("unlock_period", acc_p, 32);

    key_n[0] = 1'b0;
    tk(60);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", cfg_valid_o, 0);
    chk("mid_rst_duty", cfg_duty_o, 128);
    chk("mid_rst_period", cfg_period_o, 255);
    chk("mid_rst_mode", mode_o, 0);
    tk(3);
    n1 = acc_n;
    rst = 1'b1;
    tk(1);
    chk("mid_rel_valid", cfg_valid_o, 1);
    tk(30);
    key_n[0] = 1'b1;
    tk(10);
    chk("held_no_step", acc_n, n1 + 1);
    chk("held_duty", acc_d, 128);
    chk("held_period", acc_p, 255);

    m_d = 128;
    m_p = 255;
    m_m = 0;
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 2);
      h = $urandom_range(1, 30);
      key_n[k] = 1'b0;
      for (int j = 0; j < h; j++) begin
        rdy = 1'($urandom_range(0, 1));
        tk(1);
      end
      key_n[k] = 1'b1;
      if (k == 2) m_m = 1 - m_m;
      else if (m_m == 0) m_d = k == 0 ? (m_d + 8 > m_p ? m_p : m_d + 8) : (m_d < 8 ? 0 : m_d - 8);
      else begin
        m_p = k == 0 ? (m_p + 16 > 255 ? 255 : m_p + 16) : (m_p - 16 < 16 ? 16 : m_p - 16);
        m_d = m_d > m_p ? m_p : m_d;
      end
      rdy = 1'b1;
      tk(8);
      chk("rnd_duty", acc_d, m_d);
      chk("rnd_period", acc_p, m_p);
      chk("rnd_mode", mode_o, m_m);
      chk("rnd_idle", cfg_valid_o, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
